// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise, round-to-nearest-even and pack stage for the single-precision add/sub datapath.
// Define FP_SUBNORMAL_EN for gradual underflow; the default build flushes tiny results to zero.
module fp_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W:0]        in_exp,
    input  logic [FRAC_W+4:0]     in_mant,
    input  logic [1:0]            in_special,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] out_result,
    output logic [2:0]            out_flags
);
    localparam int MW  = FRAC_W + 4;        // hidden + fraction + G/R/S
    localparam int SW  = FRAC_W + 1;        // significand incl. hidden bit
    localparam int XW  = EXP_W + 2;         // signed exponent internals
    localparam int LZW = $clog2(MW + 1);

    localparam logic [1:0] SP_NORM = 2'b00;
    localparam logic [1:0] SP_ZERO = 2'b01;
    localparam logic [1:0] SP_INF  = 2'b10;
    localparam logic [1:0] SP_NAN  = 2'b11;

    // All-ones exponent field (2*BIAS+1 == 2^EXP_W-1 for IEEE formats)
    localparam logic signed [XW-1:0] EXP_INF = XW'(2 * BIAS + 1);

    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                found = 1'b1;
            end else if (!found) begin
                n = n + 1'b1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic                 s1_valid_r;
    logic                 s2_valid_r;
    logic                 s1_adv_s;
    logic                 in_fire_s;

    logic                 s1_sign_r;
    logic signed [XW-1:0] s1_exp_r;
    logic [MW-1:0]        s1_mant_r;
    logic [1:0]           s1_special_r;

    logic                 norm_sign_s;
    logic signed [XW-1:0] norm_exp_s;
    logic [MW-1:0]        norm_mant_s;
    logic [1:0]           norm_special_s;
    logic [LZW-1:0]       lz_s;

    logic                 tiny_s;
    logic [MW-1:0]        rnd_mant_s;
    logic                 round_up_s;
    logic                 inexact_s;
    logic [SW:0]          sum_s;
    logic signed [XW-1:0] exp_fin_s;
    logic [FRAC_W-1:0]    frac_s;
    logic [EXP_W+FRAC_W:0] res_s;
    logic [2:0]           flags_s;

`ifdef FP_SUBNORMAL_EN
    logic signed [XW-1:0] den_amt_s;
    logic [LZW-1:0]       den_sh_s;
    logic [MW-1:0]        den_mant_s;
    logic [MW-1:0]        den_lost_s;
`endif

    assign s1_adv_s  = !s2_valid_r || out_ready;
    assign in_ready  = !s1_valid_r || s1_adv_s;
    assign in_fire_s = in_valid && in_ready;
    assign out_valid = s2_valid_r;

    // Stage 1 combinational normalise: carry shifts right with sticky, otherwise shift out leading zeros
    always_comb begin
        lz_s           = lzc(in_mant[MW-1:0]);
        norm_sign_s    = in_sign;
        norm_special_s = in_special;
        norm_exp_s     = $signed({1'b0, in_exp});
        norm_mant_s    = in_mant[MW-1:0];
        if (in_special != SP_NORM) begin
            norm_mant_s = in_mant[MW-1:0];
        end else if (in_mant == '0) begin
            norm_special_s = SP_ZERO;
            norm_sign_s    = 1'b0;
        end else if (in_mant[MW]) begin
            norm_mant_s = {in_mant[MW:2], in_mant[1] | in_mant[0]};
            norm_exp_s  = norm_exp_s + XW'(1);
        end else begin
            norm_mant_s = in_mant[MW-1:0] << lz_s;
            norm_exp_s  = norm_exp_s - XW'(lz_s);
        end
    end

    // Stage 1 valid and normalised-operand registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid_r   <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_exp_r     <= '0;
            s1_mant_r    <= '0;
            s1_special_r <= SP_NORM;
        end else begin
            if (in_ready) begin
                s1_valid_r <= in_valid;
            end
            if (in_fire_s) begin
                s1_sign_r    <= norm_sign_s;
                s1_exp_r     <= norm_exp_s;
                s1_mant_r    <= norm_mant_s;
                s1_special_r <= norm_special_s;
            end
        end
    end

    // Stage 2 mantissa selection: denormalising right shift for tiny results when enabled
    always_comb begin
        tiny_s     = (s1_exp_r <= XW'(0));
        rnd_mant_s = s1_mant_r;
`ifdef FP_SUBNORMAL_EN
        den_amt_s  = XW'(1) - s1_exp_r;
        den_sh_s   = '0;
        den_mant_s = s1_mant_r;
        den_lost_s = '0;
        if (tiny_s) begin
            if (den_amt_s > XW'(MW)) begin
                den_sh_s = LZW'(MW);
            end else begin
                den_sh_s = den_amt_s[LZW-1:0];
            end
            {den_mant_s, den_lost_s} = {s1_mant_r, {MW{1'b0}}} >> den_sh_s;
            rnd_mant_s = {den_mant_s[MW-1:1], den_mant_s[0] | (|den_lost_s)};
        end else begin
            rnd_mant_s = s1_mant_r;
        end
`endif
    end

    // Stage 2 round-to-nearest-even, exponent adjust and packing
    always_comb begin
        round_up_s = rnd_mant_s[2] & (rnd_mant_s[1] | rnd_mant_s[0] | rnd_mant_s[3]);
        inexact_s  = rnd_mant_s[2] | rnd_mant_s[1] | rnd_mant_s[0];
        sum_s      = {1'b0, rnd_mant_s[MW-1:3]} + {{SW{1'b0}}, round_up_s};
        exp_fin_s  = s1_exp_r + XW'(sum_s[SW]);
        frac_s     = sum_s[SW] ? sum_s[FRAC_W:1] : sum_s[FRAC_W-1:0];
        res_s      = '0;
        flags_s    = 3'b000;
        case (s1_special_r)
            SP_ZERO: res_s = {s1_sign_r, {(EXP_W+FRAC_W){1'b0}}};
            SP_INF:  res_s = {s1_sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            SP_NAN:  res_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            default: begin
                if (tiny_s) begin
`ifdef FP_SUBNORMAL_EN
                    // A round carry into the hidden bit lands on exponent field 1: the smallest normal
                    res_s   = {s1_sign_r, {(EXP_W-1){1'b0}}, sum_s[FRAC_W], sum_s[FRAC_W-1:0]};
                    flags_s = {1'b0, inexact_s, inexact_s};
`else
                    res_s   = {s1_sign_r, {(EXP_W+FRAC_W){1'b0}}};
                    flags_s = 3'b011;
`endif
                end else if (exp_fin_s >= EXP_INF) begin
                    res_s   = {s1_sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    flags_s = 3'b101;
                end else begin
                    res_s   = {s1_sign_r, exp_fin_s[EXP_W-1:0], frac_s};
                    flags_s = {2'b00, inexact_s};
                end
            end
        endcase
    end

    // Stage 2 output registers; results hold while the consumer stalls
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s2_valid_r <= 1'b0;
            out_result <= '0;
            out_flags  <= 3'b000;
        end else if (s1_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_result <= res_s;
                out_flags  <= flags_s;
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: directed test-plan vectors, backpressure, mid-stream reset and
// randomised beats checked against an exact-arithmetic reference model.
`timescale 1ns/1ps
module tb_fp_norm_round;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [8:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic [1:0]  in_special = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  fl;
        logic [31:0] cyc;
        logic        lat;
    } sb_t;

    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        hold_pending = 1'b0;
    logic [31:0] held_res;
    logic [2:0]  held_fl;

    fp_norm_round dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_special(in_special),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Exact value is m * 2^(e-153); round to 24 significant bits (or to 2^-149 steps when tiny)
    function automatic logic [34:0] ref_model(input logic s, input int e, input logic [27:0] m, input logic [1:0] sp);
        int         p, be, k;
        longint     q, rem, half, mm;
        logic       inx;
        logic [7:0] ef;
        case (sp)
            2'b11:   return {3'b000, 32'h7FC0_0000};
            2'b10:   return {3'b000, s, 31'h7F80_0000};
            2'b01:   return {3'b000, s, 31'h0};
            default: ;
        endcase
        if (m == 28'h0) return 35'h0;
        p = 27;
        while (m[p] == 1'b0) p--;
        be = e + p - 26;
        mm = longint'(m);
`ifdef FP_SUBNORMAL_EN
        if (be <= 0) k = 4 - e;
        else k = p - 23;
`else
        if (be <= 0) return {3'b011, s, 31'h0};
        k = p - 23;
`endif
        inx = 1'b0;
        if (k <= 0) begin
            q = mm << (-k);
        end else begin
            q    = mm >> k;
            rem  = mm & ((64'sd1 << k) - 64'sd1);
            half = 64'sd1 << (k - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 64'sd1;
        end
`ifdef FP_SUBNORMAL_EN
        if (be <= 0) return {1'b0, inx, inx, s, q[30:0]};
`endif
        if (q == 64'sd16777216) begin
            q  = q >>> 1;
            be = be + 1;
        end
        if (be >= 255) return {3'b101, s, 31'h7F80_0000};
        ef = be[7:0];
        return {2'b00, inx, s, ef, q[22:0]};
    endfunction

    task automatic drive(input logic v, input logic s, input logic [8:0] e, input logic [27:0] m,
                         input logic [1:0] sp, input logic [31:0] xres, input logic [2:0] xfl,
                         input logic ordy, input logic lat, output logic acc);
        sb_t it;
        @(negedge clk);
        in_valid = v; in_sign = s; in_exp = e; in_mant = m; in_special = sp; out_ready = ordy;
        #1;
        acc = v && in_ready && arst_n;
        if (acc) begin
            it.res = xres; it.fl = xfl; it.cyc = cyc; it.lat = lat;
            sb.push_back(it);
        end
    endtask

    task automatic drive_m(input logic v, input logic s, input logic [8:0] e, input logic [27:0] m,
                           input logic [1:0] sp, input logic ordy, output logic acc);
        logic [34:0] r;
        r = ref_model(s, int'(e), m, sp);
        drive(v, s, e, m, sp, r[31:0], r[34:32], ordy, 1'b0, acc);
    endtask

    task automatic idle(input logic ordy);
        logic a;
        drive(1'b0, 1'b0, 9'd0, 28'h0, 2'b00, 32'h0, 3'b000, ordy, 1'b0, a);
    endtask

    task automatic vec(input logic s, input logic [8:0] e, input logic [27:0] m, input logic [1:0] sp,
                       input logic [31:0] xres, input logic [2:0] xfl);
        logic a;
        drive(1'b1, s, e, m, sp, xres, xfl, 1'b1, 1'b1, a);
        check("dir_accept", 32'(a), 32'd1);
    endtask

    task automatic rand_beat(output logic s, output logic [8:0] e, output logic [27:0] m, output logic [1:0] sp);
        s  = 1'($urandom_range(1, 0));
        sp = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
        case ($urandom_range(3, 0))
            0:       e = 9'($urandom_range(12, 0));
            1:       e = 9'($urandom_range(258, 245));
            default: e = 9'($urandom_range(300, 0));
        endcase
        m = 28'($urandom) >> $urandom_range(27, 0);
        if ($urandom_range(3, 0) == 0) m = {m[27:3], 3'b100};
    endtask

    // Monitor: pops on every output handshake and checks that stalled outputs hold
    initial begin : monitor
        sb_t it;
        forever begin
            @(negedge clk);
            #2;
            if (!arst_n || !out_valid) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_result", out_result, held_res);
                    check("hold_flags", 32'(out_flags), 32'(held_fl));
                end
                if (out_ready) begin
                    hold_pending = 1'b0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h expected no result", out_result);
                    end else begin
                        it = sb.pop_front();
                        check("result", out_result, it.res);
                        check("flags", 32'(out_flags), 32'(it.fl));
                        if (it.lat) check("latency", 32'(cyc) - it.cyc, 32'd2);
                    end
                end else begin
                    hold_pending = 1'b1;
                    held_res     = out_result;
                    held_fl      = out_flags;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic        a, s;
        logic [8:0]  e;
        logic [27:0] m;
        logic [1:0]  sp;
        int          n;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", out_result, 32'h0);
        check("rst_flags", 32'(out_flags), 32'd0);
        #3 arst_n = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        vec(1'b0, 9'd127, 28'h8000000, 2'b00, 32'h4000_0000, 3'b000);
        vec(1'b0, 9'd127, 28'h1000000, 2'b00, 32'h3E80_0000, 3'b000);
        vec(1'b0, 9'd127, 28'h4000004, 2'b00, 32'h3F80_0000, 3'b001);
        vec(1'b0, 9'd127, 28'h400000C, 2'b00, 32'h3F80_0002, 3'b001);
        vec(1'b1, 9'd127, 28'h400000C, 2'b00, 32'hBF80_0002, 3'b001);
        vec(1'b0, 9'd127, 28'h7FFFFFC, 2'b00, 32'h4000_0000, 3'b001);
        vec(1'b0, 9'd254, 28'h7FFFFFC, 2'b00, 32'h7F80_0000, 3'b101);
`ifdef FP_SUBNORMAL_EN
        vec(1'b0, 9'd1,   28'h1000000, 2'b00, 32'h0020_0000, 3'b000);
        vec(1'b1, 9'd10,  28'h0000001, 2'b00, 32'h8000_0040, 3'b000);
        vec(1'b0, 9'd1,   28'h3FFFFFF, 2'b00, 32'h0080_0000, 3'b011);
`else
        vec(1'b0, 9'd1,   28'h1000000, 2'b00, 32'h0000_0000, 3'b011);
        vec(1'b1, 9'd10,  28'h0000001, 2'b00, 32'h8000_0000, 3'b011);
        vec(1'b0, 9'd1,   28'h3FFFFFF, 2'b00, 32'h0000_0000, 3'b011);
`endif
        vec(1'b1, 9'd0,   28'h0000000, 2'b11, 32'h7FC0_0000, 3'b000);
        vec(1'b1, 9'd200, 28'h0000123, 2'b10, 32'hFF80_0000, 3'b000);
        vec(1'b1, 9'd50,  28'h0000000, 2'b01, 32'h8000_0000, 3'b000);
        vec(1'b1, 9'd90,  28'h0000000, 2'b00, 32'h0000_0000, 3'b000);
        repeat (3) idle(1'b1);

        // Backpressure: two beats fill the pipe, the third waits for out_ready
        drive_m(1'b1, 1'b0, 9'd130, 28'h4000000, 2'b00, 1'b0, a);
        check("bp_accept0", 32'(a), 32'd1);
        drive_m(1'b1, 1'b1, 9'd131, 28'h4000008, 2'b00, 1'b0, a);
        check("bp_accept1", 32'(a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive_m(1'b1, 1'b0, 9'd140, 28'h5555555, 2'b00, 1'b0, a);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        n = 0;
        do begin
            drive_m(1'b1, 1'b0, 9'd140, 28'h5555555, 2'b00, 1'b1, a);
            n++;
        end while (!a && n < 8);
        check("bp_resume", 32'(a), 32'd1);
        repeat (4) idle(1'b1);

        // Reset with a stalled, full pipe
        drive_m(1'b1, 1'b0, 9'd128, 28'h6000000, 2'b00, 1'b0, a);
        drive_m(1'b1, 1'b1, 9'd129, 28'h2345678, 2'b00, 1'b0, a);
        idle(1'b0);
        #2 arst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", out_result, 32'h0);
        sb.delete();
        hold_pending = 1'b0;
        idle(1'b0);
        idle(1'b1);
        #3 arst_n = 1'b1;
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 300; i++) begin
            rand_beat(s, e, m, sp);
            drive_m(1'($urandom_range(3, 0) != 0), s, e, m, sp, 1'($urandom_range(3, 0) != 0), a);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            idle(1'b1);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        repeat (3) idle(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
